nano_led_ctrl: RTL and testbench
================================

# nano_led_ctrl

Memory-mapped LED controller inside `nano_project_top` that drives the board `led` output. It sits on the Forth CPU's I/O write/read strobes as a peripheral. It converts register writes into one of four LED behaviours: off, on, PWM-dimmed, or blinking at a millisecond-based period. The output is registered so the top-level `led` pin is glitch-free.

## Interface
- `CLK_HZ`, 24_570_000: system clock frequency (40.7 ns period).
- `TICK_HZ`, 1000: blink time base; prescale = CLK_HZ/TICK_HZ, which must be ≥ 2.
- `DATA_W`, 16: I/O data width.
- `clock`  in  1  system clock; all logic on rising edge.
- `sreset`  in  1  reset, synchronous, active-high.
- `io_wr`  in  1  write strobe, one cycle per write.
- `io_rd`  in  1  read strobe.
- `io_addr`  in  2  register select.
- `io_wdata`  in  DATA_W  write data.
- `io_rdata`  out  DATA_W  read data, registered.
- `led`  out  1  LED drive, registered, active-high.

## Operation
- Registers:
  - 0 CTRL, bits[1:0] mode: 0 OFF, 1 ON, 2 PWM, 3 BLINK.
  - 1 DUTY, bits[7:0].
  - 2 PERIOD, bits[15:0], in ticks.
  - 3 STATUS, read-only: bit0 = `led`, bit1 = blink phase.
- Write behaviour:
  - Writes to STATUS are ignored.
  - Unused write bits are ignored.
  - Reads return unused bits as 0.
- Reset values: CTRL=0 (OFF), DUTY=0xFF, PERIOD=500, `led`=0, `io_rdata`=0, all counters 0, blink phase=1 (on).
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ−1.
  - Asserts `tick` for one cycle at terminal count, then wraps to 0.
- PWM:
  - 8-bit free-running counter `pwm_cnt`.
  - `pwm_on = pwm_cnt < duty_act`.
  - `duty_act` is a shadow of DUTY, loaded only when `pwm_cnt` wraps 255→0, so a duty change never truncates a PWM cycle.
  - DUTY=0 gives a constant 0. DUTY=255 gives high for 255 of 256 cycles.
- Blink:
  - On each `tick`, `blink_cnt` increments.
  - At `blink_cnt` ≥ PERIOD−1, `blink_cnt` clears and phase toggles.
  - PERIOD=0 is treated as 1, so phase toggles every tick.
  - In BLINK mode the on-phase output is `pwm_on`, so DUTY sets blink brightness.
- Next-LED value:
  - OFF → 0.
  - ON → 1, duty ignored.
  - PWM → `pwm_on`.
  - BLINK → phase & `pwm_on`.
- Any CTRL write, including rewriting the same mode:
  - clears `blink_cnt` and the prescaler;
  - sets phase=1.
- A PERIOD write does not clear `blink_cnt`. A new PERIOD smaller than the current count causes a toggle on the next tick.

## Timing
- Write at edge N: the register holds the new value after edge N. `led` reflects the new mode after edge N+1, giving one cycle of write-to-pin latency.
- DUTY write: takes effect at the next `pwm_cnt` wrap, which is at most 256 cycles later.
- Read: `io_rd` sampled at edge N; `io_rdata` is valid after edge N and held until the next read.
- Simultaneous `io_rd` and `io_wr` to the same address: the read returns the pre-write value.
- `sreset` mid-operation: all state returns to reset values on that edge, and `led`=0 the following cycle. Strobes asserted in the reset cycle are ignored.
- Blink half-period: PERIOD × CLK_HZ/TICK_HZ cycles, measured from the CTRL write.

## Structure
- Package `nano_led_pkg` holds:
  - `led_mode_t` enum (OFF/ON/PWM/BLINK);
  - address localparams `LED_CTRL`, `LED_DUTY`, `LED_PERIOD`, `LED_STATUS`;
  - reset constants for DUTY and PERIOD.
- Sub-module `nano_tick_gen` (parameters CLK_HZ, TICK_HZ) with ports `clock`, `sreset`, `clear`, `tick`.
- The top level instantiates `nano_led_ctrl` between the CPU I/O decode and the `led` port.

## Test plan
- Bench parameters: CLK_HZ=8000, TICK_HZ=1000, giving 8 cycles per tick.
- Reset: assert `sreset` for 1 cycle. Required: `led`=0 and `io_rdata`=0; reading DUTY returns 0x00FF and PERIOD returns 0x01F4.
- ON and OFF: write CTRL=1, so `led`=1 one cycle later and stays high for 1000 cycles. Then write CTRL=0, so `led`=0 one cycle later.
- PWM: write DUTY=64 then CTRL=2. After the first wrap, count exactly 64 high cycles per 256-cycle window. DUTY=0 gives all low.
- Duty shadow: in PWM mode, write DUTY mid-cycle. The current 256-cycle window keeps the old duty and the next window uses the new one.
- Blink: write PERIOD=3 then CTRL=3 with DUTY=255.
  - Phase toggles every 24 cycles.
  - STATUS bit1 alternates 1,0,1.
  - Repeat with PERIOD=0: toggles every 8 cycles.
- Reset mid-blink: assert `sreset` during the off-phase. Required: `led`=0, CTRL reads 0, STATUS reads 0x0002.

Source files
------------

// File: rtl/nano_led_pkg.sv
// Shared types and constants for the nano LED controller: mode encoding,
// register map and register reset values.
package nano_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } led_mode_t;

  localparam logic [1:0] LED_CTRL   = 2'd0;
  localparam logic [1:0] LED_DUTY   = 2'd1;
  localparam logic [1:0] LED_PERIOD = 2'd2;
  localparam logic [1:0] LED_STATUS = 2'd3;

  localparam logic [7:0]  DUTY_RST   = 8'hFF;
  localparam logic [15:0] PERIOD_RST = 16'd500;

endpackage

// File: rtl/nano_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ clocks;
// clear restarts the count so a new blink period starts from a full tick.
module nano_tick_gen #(
  parameter int CLK_HZ  = 24_570_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clock,
  input  logic sreset,
  input  logic clear,
  output logic tick
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int CW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == TERMINAL);

  always_ff @(posedge clock) begin
    if (sreset || clear || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/nano_led_ctrl.sv
// Memory-mapped LED peripheral: OFF / ON / PWM / BLINK behaviours driven by
// CPU register writes, with a registered led pin and registered read data.
module nano_led_ctrl
  import nano_led_pkg::*;
#(
  parameter int CLK_HZ  = 24_570_000,
  parameter int TICK_HZ = 1000,
  parameter int DATA_W  = 16
) (
  input  logic              clock,
  input  logic              sreset,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic [1:0]        io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              led
);

  led_mode_t         mode_reg;
  logic [7:0]        duty_reg;
  logic [7:0]        duty_act_reg;
  logic [7:0]        pwm_cnt_reg;
  logic [15:0]       period_reg;
  logic [15:0]       blink_cnt_reg;
  logic [15:0]       period_m1;
  logic              phase_reg;
  logic              led_reg;
  logic              led_next;
  logic              pwm_on;
  logic              tick;
  logic              wr_ctrl;
  logic              wr_duty;
  logic              wr_period;
  logic [DATA_W-1:0] rdata_reg;
  logic [DATA_W-1:0] rdata_next;

  assign wr_ctrl   = io_wr && (io_addr == LED_CTRL);
  assign wr_duty   = io_wr && (io_addr == LED_DUTY);
  assign wr_period = io_wr && (io_addr == LED_PERIOD);

  nano_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clock (clock),
    .sreset(sreset),
    .clear (wr_ctrl),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (sreset) begin
      mode_reg   <= MODE_OFF;
      duty_reg   <= DUTY_RST;
      period_reg <= PERIOD_RST;
    end else begin
      if (wr_ctrl)   mode_reg   <= led_mode_t'(io_wdata[1:0]);
      if (wr_duty)   duty_reg   <= io_wdata[7:0];
      if (wr_period) period_reg <= io_wdata[15:0];
    end
  end

  // Shadow duty only at the 255->0 wrap so a cycle is never cut short.
  always_ff @(posedge clock) begin
    if (sreset) begin
      pwm_cnt_reg  <= '0;
      duty_act_reg <= DUTY_RST;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      if (pwm_cnt_reg == 8'hFF) duty_act_reg <= duty_reg;
    end
  end

  assign pwm_on    = (pwm_cnt_reg < duty_act_reg);
  assign period_m1 = (period_reg == 16'd0) ? 16'd0 : (period_reg - 16'd1);

  always_ff @(posedge clock) begin
    if (sreset) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else if (wr_ctrl) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else if (tick) begin
      if (blink_cnt_reg >= period_m1) begin
        blink_cnt_reg <= '0;
        phase_reg     <= ~phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 16'd1;
      end
    end
  end

  always_comb begin
    led_next = 1'b0;
    unique case (mode_reg)
      MODE_OFF:   led_next = 1'b0;
      MODE_ON:    led_next = 1'b1;
      MODE_PWM:   led_next = pwm_on;
      MODE_BLINK: led_next = phase_reg & pwm_on;
      default:    led_next = 1'b0;
    endcase
  end

  // Read mux sees pre-write register values, so rd+wr returns the old value.
  always_comb begin
    rdata_next = '0;
    unique case (io_addr)
      LED_CTRL:   rdata_next[1:0]  = mode_reg;
      LED_DUTY:   rdata_next[7:0]  = duty_reg;
      LED_PERIOD: rdata_next[15:0] = period_reg;
      LED_STATUS: rdata_next[1:0]  = {phase_reg, led_reg};
      default:    rdata_next       = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sreset) begin
      led_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      led_reg <= led_next;
      if (io_rd) rdata_reg <= rdata_next;
    end
  end

  assign led      = led_reg;
  assign io_rdata = rdata_reg;

endmodule

// File: tb/tb_nano_led_ctrl.sv
// Directed self-checking bench for nano_led_ctrl at 8 clocks per tick.
module tb_nano_led_ctrl;
  import nano_led_pkg::*;

  logic        clock = 1'b0;
  logic        sreset;
  logic        io_wr;
  logic        io_rd;
  logic [1:0]  io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        led;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  nano_led_ctrl #(
    .CLK_HZ (8000),
    .TICK_HZ(1000),
    .DATA_W (16)
  ) dut (
    .clock   (clock),
    .sreset  (sreset),
    .io_wr   (io_wr),
    .io_rd   (io_rd),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .led     (led)
  );

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clock);
    io_wr = 1'b1; io_addr = a; io_wdata = d;
    @(negedge clock);
    io_wr = 1'b0;
    $display("wr addr=%0d data=%h", a, d);
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clock);
    io_rd = 1'b1; io_addr = a;
    @(negedge clock);
    io_rd = 1'b0;
    d = io_rdata;
    $display("rd addr=%0d data=%h", a, d);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (led === 1'b1) hi++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    sreset = 1'b1; io_wr = 1'b0; io_rd = 1'b0; io_addr = '0; io_wdata = '0;
    @(negedge clock);
    sreset = 1'b0;
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL reset_led: got %b want 0", led); end
    n_cmp++; if (io_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h want 0000", io_rdata); end
    rd(LED_DUTY, v);
    n_cmp++; if (v !== 16'h00FF) begin n_err++; $display("FAIL reset_duty: got %h want 00ff", v); end
    rd(LED_PERIOD, v);
    n_cmp++; if (v !== 16'h01F4) begin n_err++; $display("FAIL reset_period: got %h want 01f4", v); end
    rd(LED_CTRL, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL reset_ctrl: got %h want 0000", v); end
    rd(LED_STATUS, v);
    n_cmp++; if (v !== 16'h0002) begin n_err++; $display("FAIL reset_status: got %h want 0002", v); end
  endtask

  task automatic test_regs();
    logic [15:0] v;
    @(negedge clock);
    io_wr = 1'b1; io_rd = 1'b1; io_addr = LED_PERIOD; io_wdata = 16'h1234;
    @(negedge clock);
    io_wr = 1'b0; io_rd = 1'b0;
    n_cmp++; if (io_rdata !== 16'h01F4) begin n_err++; $display("FAIL rdwr_old: got %h want 01f4", io_rdata); end
    rd(LED_PERIOD, v);
    n_cmp++; if (v !== 16'h1234) begin n_err++; $display("FAIL rdwr_new: got %h want 1234", v); end
    wr(LED_DUTY, 16'hABCD);
    rd(LED_DUTY, v);
    n_cmp++; if (v !== 16'h00CD) begin n_err++; $display("FAIL duty_mask: got %h want 00cd", v); end
    wr(LED_STATUS, 16'hFFFF);
    rd(LED_STATUS, v);
    n_cmp++; if (v !== 16'h0002) begin n_err++; $display("FAIL status_ro: got %h want 0002", v); end
  endtask

  task automatic test_on_off();
    logic [15:0] v;
    int hi;
    wr(LED_CTRL, 16'hFFFD);
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL on_latency: got %b want 0", led); end
    count_high(1000, hi);
    n_cmp++; if (hi != 1000) begin n_err++; $display("FAIL on_hold: got %0d want 1000", hi); end
    rd(LED_CTRL, v);
    n_cmp++; if (v !== 16'h0001) begin n_err++; $display("FAIL ctrl_mask: got %h want 0001", v); end
    wr(LED_CTRL, 16'h0000);
    n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL off_latency: got %b want 1", led); end
    @(negedge clock);
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL off_led: got %b want 0", led); end
  endtask

  task automatic test_pwm();
    int hi;
    wr(LED_DUTY, 16'd64);
    wr(LED_CTRL, 16'd2);
    repeat (300) @(negedge clock);
    count_high(256, hi);
    n_cmp++; if (hi != 64) begin n_err++; $display("FAIL pwm_64: got %0d want 64", hi); end
    wr(LED_DUTY, 16'd0);
    repeat (300) @(negedge clock);
    count_high(256, hi);
    n_cmp++; if (hi != 0) begin n_err++; $display("FAIL pwm_0: got %0d want 0", hi); end
    wr(LED_DUTY, 16'd255);
    repeat (300) @(negedge clock);
    count_high(256, hi);
    n_cmp++; if (hi != 255) begin n_err++; $display("FAIL pwm_255: got %0d want 255", hi); end
  endtask

  task automatic test_duty_shadow();
    logic prev;
    bit   found;
    int   hi0, hi1;
    wr(LED_DUTY, 16'd64);
    repeat (300) @(negedge clock);
    prev = led; found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clock);
      if (prev === 1'b0 && led === 1'b1) found = 1'b1;
      prev = led;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL shadow_sync: got no rising edge want one within 600 cycles"); end
    hi0 = 0; hi1 = 0;
    // Sample 0 is the first high cycle of a window; write lands mid-window.
    for (int i = 0; i < 512; i++) begin
      if (i > 0) @(negedge clock);
      if (led === 1'b1) begin
        if (i < 256) hi0++; else hi1++;
      end
      io_wr = (i == 100); io_addr = LED_DUTY; io_wdata = 16'd128;
    end
    io_wr = 1'b0;
    n_cmp++; if (hi0 != 64) begin n_err++; $display("FAIL shadow_old: got %0d want 64", hi0); end
    n_cmp++; if (hi1 != 128) begin n_err++; $display("FAIL shadow_new: got %0d want 128", hi1); end
  endtask

  task automatic test_blink(input logic [15:0] period, input int seg);
    int   bad [3];
    int   off_hi, on_hi, want;
    logic [2:0] pat;
    wr(LED_PERIOD, period);
    wr(LED_DUTY, 16'd255);
    repeat (300) @(negedge clock);
    bad = '{0, 0, 0}; off_hi = 0; on_hi = 0; pat = '0;
    @(negedge clock);
    io_wr = 1'b1; io_addr = LED_CTRL; io_wdata = 16'd3;
    @(negedge clock);
    io_wr = 1'b0; io_rd = 1'b1; io_addr = LED_STATUS;
    // Continuous STATUS reads: sample k shows the phase held after edge k-1.
    for (int k = 1; k <= 3 * seg; k++) begin
      @(negedge clock);
      want = (((k - 1) / seg) % 2 == 0) ? 1 : 0;
      if (io_rdata[1] !== want[0]) bad[(k - 1) / seg]++;
      if ((k - 1) % seg == 0) pat = {pat[1:0], io_rdata[1]};
      if ((k - 1) / seg == 1 && led === 1'b1) off_hi++;
      if ((k - 1) / seg == 0 && led === 1'b1) on_hi++;
    end
    io_rd = 1'b0;
    $display("blink period=%0d phase pattern=%b", period, pat);
    n_cmp++; if (pat !== 3'b101) begin n_err++; $display("FAIL blink_pattern_p%0d: got %b want 101", period, pat); end
    for (int s = 0; s < 3; s++) begin
      n_cmp++; if (bad[s] != 0) begin n_err++; $display("FAIL blink_seg%0d_p%0d: got %0d wrong samples want 0", s, period, bad[s]); end
    end
    n_cmp++; if (off_hi != 0) begin n_err++; $display("FAIL blink_off_led_p%0d: got %0d high want 0", period, off_hi); end
    n_cmp++; if (on_hi < seg - 1) begin n_err++; $display("FAIL blink_on_led_p%0d: got %0d high want >= %0d", period, on_hi, seg - 1); end
  endtask

  task automatic test_reset_mid_blink();
    logic [15:0] v;
    wr(LED_PERIOD, 16'd3);
    wr(LED_CTRL, 16'd3);
    repeat (30) @(negedge clock);
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL mid_offphase: got %b want 0", led); end
    sreset = 1'b1; io_wr = 1'b1; io_rd = 1'b1; io_addr = LED_CTRL; io_wdata = 16'd1;
    @(negedge clock);
    sreset = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL mid_led: got %b want 0", led); end
    n_cmp++; if (io_rdata !== 16'h0000) begin n_err++; $display("FAIL mid_rdata: got %h want 0000", io_rdata); end
    @(negedge clock);
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL mid_led_next: got %b want 0", led); end
    rd(LED_CTRL, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL mid_ctrl: got %h want 0000", v); end
    rd(LED_STATUS, v);
    n_cmp++; if (v !== 16'h0002) begin n_err++; $display("FAIL mid_status: got %h want 0002", v); end
    rd(LED_DUTY, v);
    n_cmp++; if (v !== 16'h00FF) begin n_err++; $display("FAIL mid_duty: got %h want 00ff", v); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_on_off();
    test_pwm();
    test_duty_shadow();
    test_blink(16'd3, 24);
    test_blink(16'd0, 8);
    test_reset_mid_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
